// File: rtl/oled_i2c_responder.sv
// rtl/oled_i2c_responder.sv - write-only SSD1306-style I2C target
// Decodes address, control (Co, D/C#) and payload bytes; strobes each payload byte out.
module oled_i2c_responder #(
    parameter logic [6:0] CHIP_ADDR   = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        sda_oen,
    output logic        busy,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_is_data,
    output logic [15:0] byte_cnt,
    output logic        frame_done
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ADDR        = 3'd1;
    localparam logic [2:0] S_ADDR_ACK    = 3'd2;
    localparam logic [2:0] S_CTRL        = 3'd3;
    localparam logic [2:0] S_CTRL_ACK    = 3'd4;
    localparam logic [2:0] S_PAYLOAD     = 3'd5;
    localparam logic [2:0] S_PAYLOAD_ACK = 3'd6;
    localparam logic [2:0] S_IGNORE      = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, bus_start, bus_stop;

    // Bus idles high, so the synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign bus_start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    logic [2:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        got8_q, got8_d;
    logic [7:0]  shift_q, shift_d;
    logic        co_q, co_d, dc_q, dc_d;
    logic        oen_q, oen_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        is_data_q, is_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fdone_q, fdone_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        got8_d    = got8_q;
        shift_d   = shift_q;
        co_d      = co_q;
        dc_d      = dc_q;
        oen_d     = oen_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        is_data_d = is_data_q;
        cnt_d     = cnt_q;
        fdone_d   = 1'b0;

        if (bus_start) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            got8_d    = 1'b0;
            oen_d     = 1'b1;
            busy_d    = 1'b0;
            cnt_d     = 16'h0000;
        end else if (bus_stop) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            got8_d    = 1'b0;
            oen_d     = 1'b1;
            if (busy_q) begin
                fdone_d = 1'b1;
                busy_d  = 1'b0;
            end
        end else if (state_q == S_ADDR || state_q == S_CTRL || state_q == S_PAYLOAD) begin
            if (scl_rise && !got8_q) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                got8_d    = (bit_cnt_q == 3'd7);
            end else if (scl_fall && got8_q) begin
                // The falling edge ending bit 8 opens the ACK slot.
                got8_d = 1'b0;
                if (state_q == S_ADDR) begin
                    if (shift_q[7:1] == CHIP_ADDR && !shift_q[0]) begin
                        state_d = S_ADDR_ACK;
                        oen_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end else if (state_q == S_CTRL) begin
                    co_d    = shift_q[7];
                    dc_d    = shift_q[6];
                    oen_d   = 1'b0;
                    state_d = S_CTRL_ACK;
                end else begin
                    valid_d   = 1'b1;
                    data_d    = shift_q;
                    is_data_d = dc_q;
                    cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    oen_d     = 1'b0;
                    state_d   = S_PAYLOAD_ACK;
                end
            end
        end else if (state_q == S_ADDR_ACK || state_q == S_CTRL_ACK || state_q == S_PAYLOAD_ACK) begin
            if (scl_fall) begin
                oen_d = 1'b1;
                if (state_q == S_ADDR_ACK)      state_d = S_CTRL;
                else if (state_q == S_CTRL_ACK) state_d = S_PAYLOAD;
                else                            state_d = co_q ? S_CTRL : S_PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            got8_q    <= 1'b0;
            shift_q   <= 8'h00;
            co_q      <= 1'b0;
            dc_q      <= 1'b0;
            oen_q     <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            is_data_q <= 1'b0;
            cnt_q     <= 16'h0000;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            got8_q    <= got8_d;
            shift_q   <= shift_d;
            co_q      <= co_d;
            dc_q      <= dc_d;
            oen_q     <= oen_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            is_data_q <= is_data_d;
            cnt_q     <= cnt_d;
            fdone_q   <= fdone_d;
        end
    end

    assign sda_out      = 1'b0;
    assign sda_oen      = oen_q;
    assign busy         = busy_q;
    assign byte_valid   = valid_q;
    assign byte_data    = data_q;
    assign byte_is_data = is_data_q;
    assign byte_cnt     = cnt_q;
    assign frame_done   = fdone_q;

endmodule
